// File: rtl/div_share_pkg.sv
// Shared types and defaults for the divider-sharing controller.
// Holds the sequencer state encoding and the fill value used for error quotients.
package div_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 20;

  // A timed-out core reports an all-ones quotient; this is the fill bit.
  localparam logic ERR_Q_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
// The pointer register itself lives in the caller.
module rr_arbiter
  import div_share_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Sequences one shared restoring divider between NUM_REQ requesters, with
// round-robin grant, divide-by-zero bypass and a core watchdog.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int W       = DEF_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_dividend,
  input  logic [NUM_REQ*W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [W-1:0]         rsp_quotient,
  output logic [W-1:0]         rsp_remainder,
  output logic                 rsp_dbz,
  output logic                 rsp_err,
  output logic                 div_start,
  output logic [W-1:0]         div_dividend,
  output logic [W-1:0]         div_divisor,
  input  logic                 div_valid,
  input  logic [W-1:0]         div_quotient,
  input  logic [W-1:0]         div_remainder,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        id_q, id_d;
  logic [W-1:0]         dvd_q, dvd_d;
  logic [W-1:0]         dvs_q, dvs_d;
  logic [W-1:0]         quo_q, quo_d;
  logic [W-1:0]         rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        wd_q, wd_d;

  logic [NUM_REQ-1:0][W-1:0] dvd_a, dvs_a;
  logic [NUM_REQ-1:0]        gnt;
  logic [IW-1:0]             gnt_idx;
  logic                      gnt_any;
  logic [NUM_REQ-1:0]        ready_c;

  assign dvd_a = req_dividend;
  assign dvs_a = req_divisor;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    err_d     = err_q;
    wd_d      = wd_q;
    ready_c   = '0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ready_c = gnt;
          id_d    = gnt_idx;
          dvd_d   = dvd_a[gnt_idx];
          dvs_d   = dvs_a[gnt_idx];
          // Zero divisor never reaches the core.
          if (dvs_a[gnt_idx] == '0) begin
            quo_d   = '0;
            rem_d   = dvd_a[gnt_idx];
            dbz_d   = 1'b1;
            err_d   = 1'b0;
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        div_start = 1'b1;
        wd_d      = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + CW'(1);
        if (div_valid) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          dbz_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          quo_d   = {W{ERR_Q_FILL}};
          rem_d   = '0;
          dbz_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          ptr_d   = IW'(wrap_inc(int'(id_q), NUM_REQ));
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // The grant is combinational; mask it so every output reads 0 while in reset.
  assign req_ready     = rst ? '0 : ready_c;
  assign rsp_valid     = (state_q == ST_RESPOND);
  assign busy          = (state_q != ST_IDLE);
  assign rsp_id        = id_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_dbz       = dbz_q;
  assign rsp_err       = err_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: directed scenarios plus randomized traffic, checked
// against a transaction-level model of grant order, results and latency.
module tb_div_share_ctrl;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 20;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][W-1:0] dvd, dvs;
  logic [N-1:0]        req_ready;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IW-1:0]       rsp_id;
  logic [W-1:0]        rsp_quotient, rsp_remainder;
  logic                rsp_dbz, rsp_err, div_start, busy;
  logic [W-1:0]        div_dividend, div_divisor;
  logic                div_valid;
  logic [W-1:0]        core_q, core_r;
  logic                core_vld = 1'b0;
  logic                inj = 1'b0;
  bit                  core_mute = 1'b0;
  int                  core_cnt = 0;
  int                  cyc = 0, n_cmp = 0, n_err = 0, ptr_m = 0;
  int                  gcount[N];

  assign div_valid = core_vld | inj;

  div_share_ctrl #(.NUM_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(dvd), .req_divisor(dvs), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .rsp_err(rsp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid(div_valid), .div_quotient(core_q), .div_remainder(core_r),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: answers 16 cycles after the start pulse using the operands it was given.
  always @(negedge clk) begin
    if (rst) begin
      core_cnt <= 0;
      core_vld <= 1'b0;
    end else if (div_start && !core_mute) begin
      core_cnt <= 16;
      core_q   <= div_dividend / div_divisor;
      core_r   <= div_dividend % div_divisor;
      core_vld <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      core_vld <= (core_cnt == 1);
    end else begin
      core_vld <= 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transaction from grant to response handshake.
  task automatic serve(input bit keep, input int hold, input bit imm);
    int g, gk, gc, starts, n, elat;
    logic [W-1:0] a, b, eq, er;
    logic edbz, eerr;
    logic [N-1:0] oh;
    gk = -1;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin gk = k; break; end
    end
    if (gk < 0) begin check("grant_timeout", 0, 1); return; end
    if (imm) check("grant_resume", gk, 0);
    g = exp_grant(req_valid, ptr_m);
    if (g < 0) begin check("spurious_grant", req_ready, 0); return; end
    oh = '0;
    oh[g] = 1'b1;
    check("grant", req_ready, oh);
    check("busy_idle", busy, 0);
    gcount[g]++;
    a = dvd[g]; b = dvs[g]; gc = cyc;
    if (b == 0) begin
      eq = '0; er = a; edbz = 1'b1; eerr = 1'b0; elat = 1;
    end else if (core_mute) begin
      eq = '1; er = '0; edbz = 1'b0; eerr = 1'b1; elat = 2 + TO;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0; eerr = 1'b0; elat = 18;
    end
    @(negedge clk);
    if (keep) begin
      dvd[g] = W'($urandom);
      dvs[g] = W'($urandom_range(1, 300));
    end else begin
      req_valid[g] = 1'b0;
    end
    #1;
    check("ready_pulse", req_ready, 0);
    check("start", div_start, b != 0);
    if (b != 0) check("operands", {div_dividend, div_divisor}, {a, b});
    starts = int'(div_start);
    n = 0;
    while (!rsp_valid && n < 80) begin
      @(negedge clk); #1;
      starts += int'(div_start);
      n++;
    end
    check("latency", cyc - gc, elat);
    check("start_count", starts, b != 0);
    check("rsp", {rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err, busy},
          {IW'(g), eq, er, edbz, eerr, 1'b1});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check("hold", {rsp_valid, req_ready, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err},
            {1'b1, N'(0), IW'(g), eq, er, edbz, eerr});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ptr_m = (g + 1) % N;
    #1;
    check("rsp_drop", rsp_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_id, rsp_dbz, rsp_err, div_start, busy}, 0);
    check({tag, "_data"}, {rsp_quotient, rsp_remainder, div_dividend, div_divisor}, 0);
  endtask

  initial begin
    int gk;
    dvd = '0; dvs = '0;
    for (int i = 0; i < N; i++) gcount[i] = 0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Basic divide, then full-scale dividend, then divide-by-zero.
    dvd[0] = 16'd100; dvs[0] = 16'd7; req_valid[0] = 1'b1;
    serve(0, 0, 0);
    dvd[2] = 16'hFFFF; dvs[2] = 16'd1; req_valid[2] = 1'b1;
    serve(0, 0, 0);
    dvd[1] = 16'd1234; dvs[1] = 16'd0; req_valid[1] = 1'b1;
    serve(0, 0, 0);

    // Stray core done pulse while idle.
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1;
    check("inject_busy", busy, 0);
    check("inject_rsp", rsp_valid, 0);

    // Backpressure with a competing request pending.
    dvd[3] = 16'd50; dvs[3] = 16'd5; req_valid[3] = 1'b1;
    dvd[0] = 16'd9;  dvs[0] = 16'd0; req_valid[0] = 1'b1;
    serve(0, 10, 0);
    serve(0, 0, 1);

    // Continuous requests from everyone.
    for (int i = 0; i < N; i++) begin
      gcount[i] = 0;
      dvd[i] = W'($urandom);
      dvs[i] = W'($urandom_range(1, 300));
    end
    req_valid = '1;
    for (int t = 0; t < 3 * N; t++) serve(1, 0, t > 0);
    req_valid = '0;
    for (int i = 0; i < N; i++) check("fair_count", gcount[i], 3);

    // Core never answers.
    core_mute = 1'b1;
    dvd[1] = 16'd500; dvs[1] = 16'd3; req_valid[1] = 1'b1;
    serve(0, 0, 0);

    // Reset while waiting on the core.
    dvd[1] = 16'd700; dvs[1] = 16'd7; req_valid[1] = 1'b1;
    gk = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin gk = k; break; end
    end
    check("rst_grant_seen", gk >= 0, 1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("rst_in_wait", busy, 1);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    core_mute = 1'b0;
    ptr_m = 0;
    #1 check("post_reset_idle", {busy, rsp_valid}, 0);
    dvd[3] = 16'd5000; dvs[3] = 16'd77; req_valid[3] = 1'b1;
    serve(0, 0, 0);

    // Randomized traffic with occasional pre-grant withdrawals.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          dvd[i] = W'($urandom);
          case ($urandom_range(0, 4))
            0:       dvs[i] = '0;
            1:       dvs[i] = W'($urandom_range(1, 15));
            default: dvs[i] = W'($urandom_range(1, 65535));
          endcase
          req_valid[i] = 1'b1;
        end
      end
      if ($countones(req_valid) > 1 && $urandom_range(0, 4) == 0)
        req_valid[$urandom_range(0, N - 1)] = 1'b0;
      if (req_valid == '0) begin
        dvd[0] = W'($urandom);
        dvs[0] = 16'd3;
        req_valid[0] = 1'b1;
      end
      serve(0, $urandom_range(0, 2), 0);
    end
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
